port_group_packer: RTL

//  Port-group filter stage for the SME output: each input beat carries NUM_LANES rule IDs.
//  Per packet, each nonzero ID goes to an external rule-to-port-group lookup together with the

---
 rtl/port_group_packer_if.sv | 56 +++++
 rtl/port_group_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/port_group_packer_if.sv
// Streaming, lookup and statistics signals of port_group_packer.
// slave is the packer's view, master is the surrounding datapath's view.
interface port_group_packer_if #(
    parameter int unsigned NUM_LANES   = 8,
    parameter int unsigned RULE_AWIDTH = 13,
    parameter int unsigned OUT_BEATS   = 4,
    parameter int unsigned META_W      = 128
);
    logic                              in_match_sop;
    logic                              in_match_eop;
    logic [NUM_LANES*16-1:0]           in_match_data;
    logic                              in_match_valid;
    logic                              in_match_ready;
    logic                              in_meta_valid;
    logic [META_W-1:0]                 in_meta_data;
    logic [15:0]                       in_meta_sport;
    logic [15:0]                       in_meta_dport;
    logic                              in_meta_tcp;
    logic                              in_meta_ready;
    logic                              lk_valid;
    logic [NUM_LANES*RULE_AWIDTH-1:0]  lk_addr;
    logic [15:0]                       lk_sport;
    logic [15:0]                       lk_dport;
    logic                              lk_tcp;
    logic [NUM_LANES-1:0]              lk_hit;
    logic [OUT_BEATS*NUM_LANES*16-1:0] out_match_data;
    logic                              out_match_eop;
    logic [$clog2(OUT_BEATS):0]        out_match_empty;
    logic                              out_match_valid;
    logic                              out_match_ready;
    logic                              out_meta_valid;
    logic [META_W-1:0]                 out_meta_data;
    logic                              out_meta_ready;
    logic [31:0]                       lane_in_cnt;
    logic [31:0]                       lane_hit_cnt;

    modport slave (
        input  in_match_sop, in_match_eop, in_match_data, in_match_valid,
        input  in_meta_valid, in_meta_data, in_meta_sport, in_meta_dport, in_meta_tcp,
        input  lk_hit, out_match_ready, out_meta_ready,
        output in_match_ready, in_meta_ready,
        output lk_valid, lk_addr, lk_sport, lk_dport, lk_tcp,
        output out_match_data, out_match_eop, out_match_empty, out_match_valid,
        output out_meta_valid, out_meta_data, lane_in_cnt, lane_hit_cnt
    );

    modport master (
        output in_match_sop, in_match_eop, in_match_data, in_match_valid,
        output in_meta_valid, in_meta_data, in_meta_sport, in_meta_dport, in_meta_tcp,
        output lk_hit, out_match_ready, out_meta_ready,
        input  in_match_ready, in_meta_ready,
        input  lk_valid, lk_addr, lk_sport, lk_dport, lk_tcp,
        input  out_match_data, out_match_eop, out_match_empty, out_match_valid,
        input  out_meta_valid, out_meta_data, lane_in_cnt, lane_hit_cnt
    );
endinterface

// File: rtl/port_group_packer.sv
// Port-group filter: looks up every nonzero rule ID, zeroes misses, buffers surviving
// beats in a credit-protected FIFO and packs OUT_BEATS of them per output word.
module port_group_packer #(
    parameter int unsigned NUM_LANES   = 8,
    parameter int unsigned RULE_AWIDTH = 13,
    parameter int unsigned LK_LAT      = 4,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned OUT_BEATS   = 4,
    parameter int unsigned META_W      = 128
) (
    input logic             clk,
    input logic             rst_n,
    port_group_packer_if.slave bus
);
    localparam int unsigned DW = NUM_LANES * 16;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + LK_LAT) + 2;
    localparam int unsigned SW = $clog2(OUT_BEATS) + 1;
    localparam int unsigned L  = LK_LAT - 1;

    typedef enum logic [1:0] {IDLE, RULE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            sport_q, dport_q;
    logic                   tcp_q, first_q, omv_q, meta_load;
    logic [META_W-1:0]      meta_q, omd_q;
    logic                   acc, credit_ok;
    logic [CW-1:0]          used_q, inflight;
    logic [NUM_LANES-1:0]   in_nz, kept;
    logic [LK_LAT-1:0]      pv_q, pe_q;
    logic [NUM_LANES-1:0]   pn_q [LK_LAT];
    logic [DW-1:0]          pd_q [LK_LAT];
    logic [DW-1:0]          f_data;
    logic                   push, pop;
    logic [31:0]            in_inc, hit_inc, in_cnt_q, hit_cnt_q;
    logic [DW+1:0]          mem [FIFO_DEPTH];
    logic [DW+1:0]          rd;
    logic [PW-1:0]          wp_q, rp_q;
    logic [SW-1:0]          cnt_q, base_cnt, n_cnt, empty_q;
    logic [OUT_BEATS*DW-1:0] word_q, word_d;
    logic                   ov_q, eop_q, emit;

    always_comb begin
        state_d            = state_q;
        meta_load          = 1'b0;
        bus.in_match_ready = 1'b0;
        bus.in_meta_ready  = 1'b0;
        unique case (state_q)
            IDLE: if (bus.in_meta_valid) state_d = RULE;
            RULE: begin
                bus.in_match_ready = credit_ok;
                if (bus.in_match_valid && credit_ok && bus.in_match_eop) state_d = DONE;
            end
            DONE: if (!omv_q) begin
                meta_load         = 1'b1;
                bus.in_meta_ready = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc = bus.in_match_valid && bus.in_match_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sport_q <= '0;
            dport_q <= '0;
            tcp_q   <= 1'b0;
            meta_q  <= '0;
            first_q <= 1'b0;
            omv_q   <= 1'b0;
            omd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.in_meta_valid) begin
                sport_q <= bus.in_meta_sport;
                dport_q <= bus.in_meta_dport;
                tcp_q   <= bus.in_meta_tcp;
                meta_q  <= bus.in_meta_data;
                first_q <= 1'b1;
            end else if (acc) begin
                first_q <= 1'b0;
            end
            if (meta_load) begin
                omv_q <= 1'b1;
                omd_q <= meta_q;
            end else if (omv_q && bus.out_meta_ready) begin
                omv_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.lk_addr = '0;
        in_nz       = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            bus.lk_addr[i*RULE_AWIDTH +: RULE_AWIDTH] = bus.in_match_data[i*16 +: RULE_AWIDTH];
            in_nz[i] = bus.in_match_data[i*16 +: RULE_AWIDTH] != '0;
        end
    end

    assign bus.lk_valid = acc;
    assign bus.lk_sport = sport_q;
    assign bus.lk_dport = dport_q;
    assign bus.lk_tcp   = tcp_q;

    // Stage L lines up with lk_hit for the beat accepted LK_LAT cycles earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pe_q <= '0;
            for (int unsigned i = 0; i < LK_LAT; i++) begin
                pn_q[i] <= '0;
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= acc;
            pe_q[0] <= acc && bus.in_match_eop;
            pn_q[0] <= in_nz;
            pd_q[0] <= bus.in_match_data;
            for (int unsigned i = 1; i < LK_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pe_q[i] <= pe_q[i-1];
                pn_q[i] <= pn_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    always_comb begin
        kept     = pv_q[L] ? (pn_q[L] & bus.lk_hit) : '0;
        f_data   = '0;
        in_inc   = '0;
        hit_inc  = '0;
        inflight = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (kept[i]) f_data[i*16 +: 16] = pd_q[L][i*16 +: 16];
            if (pv_q[L]) in_inc = in_inc + 32'(pn_q[L][i]);
            hit_inc = hit_inc + 32'(kept[i]);
        end
        for (int unsigned i = 0; i < LK_LAT; i++) inflight = inflight + CW'(pv_q[i]);
        push = pv_q[L] && ((|kept) || pe_q[L]);
    end

    // Credit covers every beat still in the lookup pipe, so the FIFO cannot overflow.
    assign credit_ok = (used_q + inflight) <= CW'(FIFO_DEPTH - 2);

    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= {pe_q[L], |kept, f_data};
    end

    assign rd  = mem[rp_q];
    assign pop = (used_q != '0) && (!ov_q || bus.out_match_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q      <= '0;
            rp_q      <= '0;
            used_q    <= '0;
            in_cnt_q  <= '0;
            hit_cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + PW'(1);
            if (pop)  rp_q <= rp_q + PW'(1);
            used_q    <= used_q + CW'(push) - CW'(pop);
            in_cnt_q  <= in_cnt_q + in_inc;
            hit_cnt_q <= hit_cnt_q + hit_inc;
        end
    end

    // A word leaving this cycle frees the register, so packing restarts from an empty word.
    always_comb begin
        base_cnt = ov_q ? '0 : cnt_q;
        word_d   = ov_q ? '0 : word_q;
        n_cnt    = base_cnt;
        emit     = 1'b0;
        if (pop) begin
            if (rd[DW]) begin
                for (int unsigned s = 0; s < OUT_BEATS; s++)
                    if (SW'(s) == base_cnt) word_d[s*DW +: DW] = rd[DW-1:0];
                n_cnt = base_cnt + SW'(1);
            end
            emit = rd[DW+1] || (n_cnt == SW'(OUT_BEATS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q    <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
        end else if (pop) begin
            word_q <= word_d;
            cnt_q  <= emit ? '0 : n_cnt;
            ov_q   <= emit;
            if (emit) begin
                eop_q   <= rd[DW+1];
                empty_q <= SW'(OUT_BEATS) - n_cnt;
            end
        end else if (ov_q && bus.out_match_ready) begin
            ov_q   <= 1'b0;
            cnt_q  <= '0;
            word_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && used_q == CW'(FIFO_DEPTH)));
            assert (!(acc && bus.in_match_sop && !first_q));
        end
    end

    assign bus.out_match_data  = word_q;
    assign bus.out_match_eop   = eop_q;
    assign bus.out_match_empty = empty_q;
    assign bus.out_match_valid = ov_q;
    assign bus.out_meta_valid  = omv_q;
    assign bus.out_meta_data   = omd_q;
    assign bus.lane_in_cnt     = in_cnt_q;
    assign bus.lane_hit_cnt    = hit_cnt_q;
endmodule
